// File: rtl/pll_reconfig_pkg.sv
// Shared types and defaults for the PLL reconfiguration controller.
//   state_e : controller FSM states
//   div_t   : one complete divider set (IDSEL / FBDSEL / ODSEL, PLL encoding)
//   DEF_*   : default parameter values used by the top level
package pll_reconfig_pkg;

    localparam int DIV_W = 6;

    localparam logic [DIV_W-1:0] DEF_INIT_SEL     = 6'd0;
    localparam int               DEF_RST_CYCLES   = 16;
    localparam int               DEF_GATE_CYCLES  = 4;
    localparam int               DEF_LOCK_STABLE  = 8;
    localparam int               DEF_LOCK_TIMEOUT = 65535;
    localparam int               DEF_MAX_RETRY    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_UNGATE,
        ST_FAULT
    } state_e;

    typedef struct packed {
        logic [DIV_W-1:0] idsel;
        logic [DIV_W-1:0] fbdsel;
        logic [DIV_W-1:0] odsel;
    } div_t;

    function automatic div_t mk_div(input logic [DIV_W-1:0] id,
                                    input logic [DIV_W-1:0] fb,
                                    input logic [DIV_W-1:0] od);
        div_t d;
        d.idsel  = id;
        d.fbdsel = fb;
        d.odsel  = od;
        return d;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Request handshake between a requester and pll_reconfig_ctrl.
//   req_valid  : requester offers a divider set
//   req_ready  : controller can accept (transfer when both high)
//   req_*sel   : requested divider codes, PLL encoding
// modport master = requester side, modport slave = controller side.
interface pll_reconfig_ctrl_if;
    import pll_reconfig_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [DIV_W-1:0] req_idsel;
    logic [DIV_W-1:0] req_fbdsel;
    logic [DIV_W-1:0] req_odsel;

    modport master (
        output req_valid, req_idsel, req_fbdsel, req_odsel,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_idsel, req_fbdsel, req_odsel,
        output req_ready
    );

endinterface

// File: rtl/pll_lock_sync.sv
// Synchronises the asynchronous PLL lock and qualifies it.
//   clk_i, rst_i : clock, synchronous active-high reset
//   lock_i       : raw PLL LOCK (asynchronous)
//   clr_i        : restart both run counters (held while the PLL is in reset)
//   stable_hi    : current synced sample is the LOCK_STABLE-th consecutive high
//   stable_lo    : current synced sample is the LOCK_STABLE-th consecutive low
module pll_lock_sync #(
    parameter int LOCK_STABLE = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lock_i,
    input  logic clr_i,
    output logic stable_hi,
    output logic stable_lo
);

    localparam int            CW  = $clog2(LOCK_STABLE + 1);
    // Counters hold the number of *previous* matching samples, so the
    // qualifier fires on the sample that completes the run, not one later.
    localparam logic [CW-1:0] THR = CW'(LOCK_STABLE - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic          lock_s;

    assign lock_s = sync_q[1];

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (clr_i) begin
            hi_cnt_d = '0;
            lo_cnt_d = '0;
        end else if (lock_s) begin
            lo_cnt_d = '0;
            if (hi_cnt_q != THR) hi_cnt_d = hi_cnt_q + CW'(1);
        end else begin
            hi_cnt_d = '0;
            if (lo_cnt_q != THR) lo_cnt_d = lo_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], lock_i};
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

    assign stable_hi = !clr_i &&  lock_s && (hi_cnt_q == THR);
    assign stable_lo = !clr_i && !lock_s && (lo_cnt_q == THR);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL divider reconfiguration controller.
// Accepts a divider set, gates the downstream clock, holds the PLL in reset
// while the new codes are applied, waits for a qualified lock (with timeout
// and retry) and then ungates. In IDLE it also watches for lock loss and
// re-runs the reset/lock sequence with the current codes.
//   sys_clk, reset       : clock, synchronous active-high reset
//   req_if (slave)       : request handshake + requested codes
//   pll_lock             : raw PLL LOCK
//   pll_reset, pll_*sel  : PLL control
//   clk_gate_en          : downstream may use the PLL clock
//   busy                 : sequence in progress (not IDLE / FAULT)
//   done, err, lock_lost : one-cycle event pulses
module pll_reconfig_ctrl
    import pll_reconfig_pkg::*;
#(
    parameter logic [DIV_W-1:0] INIT_IDSEL   = DEF_INIT_SEL,
    parameter logic [DIV_W-1:0] INIT_FBDSEL  = DEF_INIT_SEL,
    parameter logic [DIV_W-1:0] INIT_ODSEL   = DEF_INIT_SEL,
    parameter int               RST_CYCLES   = DEF_RST_CYCLES,
    parameter int               GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int               LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int               LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int               MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic                sys_clk,
    input  logic                reset,
    pll_reconfig_ctrl_if.slave  req_if,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic [DIV_W-1:0]    pll_idsel,
    output logic [DIV_W-1:0]    pll_fbdsel,
    output logic [DIV_W-1:0]    pll_odsel,
    output logic                clk_gate_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                lock_lost
);

    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    localparam div_t INIT_DIV = mk_div(INIT_IDSEL, INIT_FBDSEL, INIT_ODSEL);

    state_e        state_q;
    logic [GW-1:0] gate_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic [RW-1:0] retry_q, retry_d;
    div_t          shadow_q;
    div_t          sel_q;
    logic          pll_reset_q;
    logic          gate_en_q;
    logic          done_q, err_q, lost_q;

    logic          stable_hi, stable_lo;
    logic          accept;
    logic          hs;
    div_t          req_div;

    // Lock run counters restart while the PLL is held in reset so WAIT_LOCK
    // always judges a fresh run of lock samples.
    pll_lock_sync #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_sync (
        .clk_i     (sys_clk),
        .rst_i     (reset),
        .lock_i    (pll_lock),
        .clr_i     (state_q == ST_HOLD),
        .stable_hi (stable_hi),
        .stable_lo (stable_lo)
    );

    assign accept  = (state_q == ST_IDLE) || (state_q == ST_FAULT);
    assign hs      = accept && req_if.req_valid;
    assign req_div = mk_div(req_if.req_idsel, req_if.req_fbdsel, req_if.req_odsel);
    assign retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            gate_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            shadow_q    <= INIT_DIV;
            sel_q       <= INIT_DIV;
            pll_reset_q <= 1'b1;
            gate_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            lost_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FAULT: begin
                    if (hs) begin
                        shadow_q   <= req_div;
                        retry_q    <= '0;
                        gate_cnt_q <= '0;
                        gate_en_q  <= 1'b0;
                        state_q    <= ST_GATE;
                    end else if (state_q == ST_IDLE && stable_lo) begin
                        // Relock with the codes already on the PLL; pll_*sel
                        // are untouched so they never move with reset low.
                        lost_q      <= 1'b1;
                        gate_en_q   <= 1'b0;
                        retry_q     <= '0;
                        shadow_q    <= sel_q;
                        pll_reset_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_GATE: begin
                    if (gate_cnt_q == GATE_LAST) begin
                        // New codes land together with the reset assertion.
                        sel_q       <= shadow_q;
                        pll_reset_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= ST_HOLD;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GW'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        pll_reset_q <= 1'b0;
                        to_cnt_q    <= '0;
                        state_q     <= ST_WAIT_LOCK;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (stable_hi) begin
                        gate_en_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= ST_UNGATE;
                    end else if (to_cnt_q == TO_LAST) begin
                        retry_q <= retry_d;
                        if (retry_d < RETRY_MAX) begin
                            pll_reset_q <= 1'b1;
                            hold_cnt_q  <= '0;
                            state_q     <= ST_HOLD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_FAULT;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                ST_UNGATE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    // Unreachable encodings park safely in FAULT.
                    pll_reset_q <= 1'b0;
                    gate_en_q   <= 1'b0;
                    state_q     <= ST_FAULT;
                end
            endcase
        end
    end

    assign req_if.req_ready = accept;
    assign busy             = !accept;
    assign pll_reset        = pll_reset_q;
    assign pll_idsel        = sel_q.idsel;
    assign pll_fbdsel       = sel_q.fbdsel;
    assign pll_odsel        = sel_q.odsel;
    assign clk_gate_en      = gate_en_q;
    assign done             = done_q;
    assign err              = err_q;
    assign lock_lost        = lost_q;

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- INIT_IDSEL, 6'd0: PLL IDSEL value applied at reset.
- INIT_FBDSEL, 6'd0: PLL FBDSEL value applied at reset.
- INIT_ODSEL, 6'd0: PLL ODSEL value applied at reset.
- RST_CYCLES, 16: pll_reset hold length, in sys_clk cycles.
- GATE_CYCLES, 4: quiesce wait after clk_gate_en falls.
- LOCK_STABLE, 8: consecutive synced-lock-high cycles required to declare lock.
- LOCK_TIMEOUT, 65535: maximum cycles allowed in WAIT_LOCK per attempt.
- MAX_RETRY, 3: attempts per request before FAULT.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- sys_clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- req_valid, in, 1: new divider set offered.
- req_ready, out, 1: request accepted when high together with req_valid.
- req_idsel / req_fbdsel / req_odsel, in, 6 each: requested divider codes, already in PLL encoding.
- pll_lock, in, 1: asynchronous PLL LOCK output.
- pll_reset, out, 1: drives PLL RESET.
- pll_idsel / pll_fbdsel / pll_odsel, out, 6 each: drive PLL IDSEL/FBDSEL/ODSEL.
- clk_gate_en, out, 1: downstream may use PLL clock.
- busy, out, 1: high in every state except IDLE and FAULT.
- done, out, 1: one-cycle pulse on successful lock.
- err, out, 1: one-cycle pulse on entering FAULT.
- lock_lost, out, 1: one-cycle pulse on loss of lock in IDLE.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchronizer; all decisions use the synced value (lock_s).
REQ-004 States SHALL be IDLE, GATE, HOLD, WAIT_LOCK, UNGATE, FAULT.
REQ-005 req_ready SHALL be 1 only in IDLE and FAULT; a handshake latches the three codes into shadow registers and clears the retry count.
REQ-006 After a handshake the FSM SHALL go to GATE: clk_gate_en=0 on the next cycle; it waits GATE_CYCLES cycles.
REQ-007 On GATE exit, pll_*sel SHALL load from shadow and pll_reset=1 in the same cycle; the FSM enters HOLD for exactly RST_CYCLES cycles.
REQ-008 pll_*sel SHALL change only when pll_reset is being asserted, never while pll_reset=0.
REQ-009 WAIT_LOCK SHALL deassert pll_reset and count consecutive lock_s=1 cycles; any lock_s=0 clears the count; on reaching LOCK_STABLE it goes to UNGATE.
REQ-010 If WAIT_LOCK reaches LOCK_TIMEOUT cycles, the FSM SHALL increment the retry count and re-enter HOLD if retry<MAX_RETRY; otherwise it enters FAULT and pulses err.
REQ-011 UNGATE SHALL set clk_gate_en=1, pulse done, and return to IDLE in one cycle.
REQ-012 In IDLE, lock_s=0 for LOCK_STABLE consecutive cycles SHALL pulse lock_lost, drop clk_gate_en, and enter HOLD with the current codes and the retry count cleared.
REQ-013 FAULT SHALL hold pll_reset=0, clk_gate_en=0 and the last codes; only a new handshake leaves it.
REQ-014 req_valid outside IDLE/FAULT SHALL be ignored, with no state change; the requester holds the request.
REQ-015 Counters SHALL saturate and never wrap; the timeout counter is $clog2(LOCK_TIMEOUT+1) bits wide.

Reset
REQ-016 Reset SHALL set pll_*sel=INIT_*, pll_reset=1, clk_gate_en=0, busy=1, done=err=lock_lost=0, req_ready=0, counters=0, synchronizer=0, and state=HOLD.
REQ-017 Reset asserted mid-sequence, including WAIT_LOCK, SHALL abandon the request and restart from REQ-016 on the next cycle.

Structure
REQ-018 Package pll_reconfig_pkg SHALL hold the state enum, a 3x6-bit divider struct, and the default constants.
REQ-019 Sub-module pll_lock_sync SHALL implement the synchronizer and the LOCK_STABLE consecutive counter, outputting stable_hi and stable_lo.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response.
- Reset release, lock model rises 40 cycles later -> pll_reset high exactly 16 cycles, done pulse 8 cycles after synced lock, clk_gate_en=1.
- Request codes 0x3C/0x3E/0x20 in IDLE -> clk_gate_en falls, 4 cycles later pll_*sel update with pll_reset=1 the same cycle, done after lock.
- Lock never asserts, LOCK_TIMEOUT=100 -> three HOLD/WAIT_LOCK attempts, err pulse, FAULT, req_ready=1.
- Lock glitches low for 1 cycle at stable count 5 in WAIT_LOCK -> count restarts, done delayed by 6 cycles.
- Lock drops for 8 cycles in IDLE -> lock_lost pulse, clk_gate_en=0, relock restores clk_gate_en; a 7-cycle drop causes no action.
- req_valid held during HOLD, then reset asserted in WAIT_LOCK -> request not accepted, outputs match REQ-016 next cycle.
